// File: rtl/sub_spi_pkg.sv
// Shared types and defaults for the SPI subordinate control stage.
package sub_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } sub_state_e;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam logic [7:0]  DUMMY_BYTE_DEF = 8'hFF;

endpackage

// File: rtl/sub_edge_sync.sv
// N-flop synchroniser for an asynchronous pad, followed by a history flop
// and registered one-cycle rise/fall pulses.
module sub_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Pulses land SYNC_STAGES+1 clocks after the pad edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
      hist_q <= synced;
      rise   <= synced & ~hist_q;
      fall   <= ~synced & hist_q;
    end
  end

endmodule

// File: rtl/sub_spi_ctrl.sv
// SPI subordinate control: pad synchronisation, frame sequencing, shift/load
// strobes and FIFO handshakes for mode-0 transfers.
module sub_spi_ctrl
  import sub_spi_pkg::*;
#(
  parameter int unsigned           SYNC_STAGES = 2,
  parameter int unsigned           DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] DUMMY_BYTE  = DATA_WIDTH'(DUMMY_BYTE_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk_pad_i,
  input  logic                  cs_n_pad_i,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] sub_tx,
  output logic                  load_from_fifo,
  output logic                  slave_transfer_shift_en,
  output logic                  slave_receive_shift_en,
  input  logic [DATA_WIDTH-1:0] sub_rx,
  output logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_full,
  output logic                  busy,
  output logic                  underrun,
  output logic                  overrun,
  input  logic                  err_clr
);

  localparam int unsigned    CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  sub_state_e       state_q;
  sub_state_e       state_d;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             sclk_rise;
  logic             sclk_fall;
  logic             cs_rise;
  logic             cs_fall;
  logic             rx_push;
  logic             rx_drop;
  logic             send_dummy;

  sub_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .pad  (sclk_pad_i),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  sub_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .pad  (cs_n_pad_i),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state; in DONE a same-cycle cs_n rise is the only way CS can have left.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = LOAD;
      LOAD:    state_d = cs_rise ? IDLE : SHIFT;
      SHIFT: begin
        if (cs_rise)                              state_d = IDLE;
        else if (sclk_rise && bit_cnt_q == LAST_BIT) state_d = DONE;
      end
      DONE:    state_d = cs_rise ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Strobes decoded from the registered state and the registered edge pulses.
  always_comb begin
    tx_ready                = 1'b0;
    load_from_fifo          = 1'b0;
    slave_receive_shift_en  = 1'b0;
    slave_transfer_shift_en = 1'b0;
    busy                    = (state_q != IDLE);
    case (state_q)
      LOAD: begin
        load_from_fifo = 1'b1;
        tx_ready       = tx_valid;
      end
      SHIFT: begin
        if (!cs_rise) begin
          slave_receive_shift_en  = sclk_rise;
          slave_transfer_shift_en = sclk_fall && (bit_cnt_q != '0) && (bit_cnt_q <= LAST_BIT);
        end
      end
      default: ;
    endcase
  end

  assign rx_push    = (state_q == DONE) && !rx_full;
  assign rx_drop    = (state_q == DONE) && rx_full;
  assign send_dummy = (state_q == LOAD) && !tx_valid;

  // Bit counter and byte/flag datapath; flag set wins over err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= '0;
      sub_tx    <= DUMMY_BYTE;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      underrun  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_valid <= rx_push;
      if (rx_push) rx_data <= sub_rx;

      case (state_q)
        IDLE: bit_cnt_q <= '0;
        LOAD: begin
          bit_cnt_q <= '0;
          sub_tx    <= tx_valid ? tx_data : DUMMY_BYTE;
        end
        SHIFT: begin
          if (cs_rise)        bit_cnt_q <= '0;
          else if (sclk_rise) bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        end
        default: ;
      endcase

      if (send_dummy)   underrun <= 1'b1;
      else if (err_clr) underrun <= 1'b0;

      if (rx_drop)      overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
    end
  end

endmodule
